// File: rtl/mux_src_arbiter.sv
// mux_src_arbiter: round-robin ownership arbiter driving the 5-input source mux selector.
// Optional ownership watchdog is enabled by defining MUX_SRC_ARB_TIMEOUT_EN.
module mux_src_arbiter #(
  parameter int N_REQ = 5,
  parameter int SEL_W = 3
`ifdef MUX_SRC_ARB_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 16
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic [SEL_W-1:0] selector,
  output logic [N_REQ-1:0] grant,
  output logic             busy,
  output logic             timeout
);
  typedef enum logic {IDLE, OWNED} state_t;
  state_t r_state, w_state_n;
  logic [SEL_W-1:0] r_last, r_sel, w_win, w_idx;
  logic [SEL_W:0] w_sum;
  logic [N_REQ-1:0] r_grant;
  logic w_any, w_to, w_rel, w_take;
  // Scan farthest-first so the nearest requester after r_last wins; r_last itself comes last.
  always_comb begin
    w_win = r_last;
    w_sum = '0;
    w_idx = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      w_sum = {1'b0, r_last} + (SEL_W+1)'(k);
      w_sum = w_sum >= (SEL_W+1)'(N_REQ) ? w_sum - (SEL_W+1)'(N_REQ) : w_sum;
      w_idx = w_sum[SEL_W-1:0];
      w_win = req[w_idx] ? w_idx : w_win;
    end
  end
  assign w_any = |req;
`ifdef MUX_SRC_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] r_cnt;
  logic r_timeout;
  assign w_to = r_state == OWNED && !done && r_cnt == CNT_W'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_cnt <= (w_state_n == OWNED && !w_take) ? r_cnt + 1'b1 : '0;
      r_timeout <= w_to;
    end
  end
  assign timeout = r_timeout;
`else
  assign w_to = 1'b0;
  assign timeout = 1'b0;
`endif
  assign w_rel = r_state == OWNED && (done || w_to);
  assign w_take = (r_state == IDLE || w_rel) && w_any;
  always_comb w_state_n = w_take ? OWNED : (w_rel ? IDLE : r_state);
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_last <= SEL_W'(N_REQ - 1);
      r_sel <= '0;
      r_grant <= '0;
    end else begin
      r_state <= w_state_n;
      if (w_take) begin
        r_last <= w_win;
        r_sel <= w_win;
        r_grant <= N_REQ'(1) << w_win;
      end else if (w_rel) begin
        r_grant <= '0;
      end
    end
  end
  assign selector = r_sel;
  assign grant = r_grant;
  assign busy = r_state == OWNED;
endmodule

// File: tb/tb_mux_src_arbiter.sv
// tb_mux_src_arbiter: directed and random checks of mux_src_arbiter against an ownership model.
module tb_mux_src_arbiter;
  logic clk = 1'b0;
  logic reset, done, busy, timeout;
  logic [4:0] req, grant;
  logic [2:0] selector;
  int n_tests = 0, n_fail = 0;
  int m_owner = -1, m_last = 4, m_sel = 0, m_age = 0;
  bit m_to = 1'b0;
  int fair_seq[6] = '{0, 1, 2, 3, 4, 0};

  always #5 clk = ~clk;

  mux_src_arbiter dut (
    .clk(clk), .reset(reset), .req(req), .done(done),
    .selector(selector), .grant(grant), .busy(busy), .timeout(timeout)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic int pick(input logic [4:0] r, input int last);
    for (int k = 1; k <= 5; k++)
      if (r[(last + k) % 5]) return (last + k) % 5;
    return -1;
  endfunction

  task automatic model(input logic rs, input logic [4:0] r, input logic d);
    bit forced;
    int w;
    m_to = 1'b0;
    forced = 1'b0;
    if (rs) begin
      m_owner = -1;
      m_last = 4;
      m_sel = 0;
      m_age = 0;
      return;
    end
`ifdef MUX_SRC_ARB_TIMEOUT_EN
    forced = m_owner >= 0 && !d && m_age == 16;
`endif
    if (m_owner < 0 || d || forced) begin
      m_to = forced;
      w = pick(r, m_last);
      if (w >= 0) begin
        m_owner = w;
        m_last = w;
        m_sel = w;
        m_age = 1;
      end else begin
        m_owner = -1;
        m_age = 0;
      end
    end else begin
      m_age++;
    end
  endtask

  task automatic step(input logic rs, input logic [4:0] r, input logic d);
    reset = rs;
    req = r;
    done = d;
    @(posedge clk);
    model(rs, r, d);
    #1;
    check("grant", grant, m_owner < 0 ? 0 : 1 << m_owner);
    check("selector", selector, m_sel);
    check("busy", busy, m_owner >= 0);
    check("timeout", timeout, m_to);
  endtask

  initial begin
    step(1, 5'b0, 0);
    step(1, 5'b0, 0);
    check("rst_grant", grant, 5'b00000);
    check("rst_sel", selector, 3'd0);
    check("rst_busy", busy, 1'b0);
    step(0, 5'b00100, 0);
    check("t1_grant", grant, 5'b00100);
    check("t1_sel", selector, 3'd2);
    check("t1_busy", busy, 1'b1);
    step(0, 5'b00000, 1);
    check("t1_rel_grant", grant, 5'b00000);
    check("t1_rel_busy", busy, 1'b0);
    check("t1_rel_sel", selector, 3'd2);
    step(1, 5'b0, 0);
    step(0, 5'b11111, 0);
    check("fair_sel0", selector, fair_seq[0]);
    for (int i = 1; i < 6; i++) begin
      step(0, 5'b11111, 1);
      check("fair_sel", selector, fair_seq[i]);
      check("fair_grant", grant, 1 << fair_seq[i]);
    end
    step(1, 5'b0, 0);
    step(0, 5'b01000, 0);
    for (int i = 0; i < 5; i++) begin
      step(0, 5'b00001, 0);
      check("hold_grant", grant, 5'b01000);
      check("hold_sel", selector, 3'd3);
    end
    step(0, 5'b00001, 1);
    check("hold_next", grant, 5'b00001);
    step(1, 5'b0, 0);
    step(0, 5'b00010, 0);
    step(0, 5'b00010, 1);
    check("regrant_grant", grant, 5'b00010);
    check("regrant_busy", busy, 1'b1);
    step(1, 5'b0, 0);
    step(0, 5'b10000, 0);
    check("own4_grant", grant, 5'b10000);
    step(1, 5'b10000, 1);
    check("mid_rst_grant", grant, 5'b00000);
    check("mid_rst_sel", selector, 3'd0);
    check("mid_rst_busy", busy, 1'b0);
    step(0, 5'b10001, 0);
    check("post_rst_grant", grant, 5'b00001);
    step(1, 5'b0, 0);
    step(0, 5'b00001, 0);
    for (int i = 0; i < 120; i++) step(0, 5'b00011, 0);
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 49) == 0, 5'($urandom & $urandom), $urandom_range(0, 2) == 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
